// File: rtl/bitcount_seq.sv
// bitcount_seq: multi-cycle popcount of a DATA_W-bit vector, SLICE_W bits per cycle via byte lookups.
// Define BITCOUNT_SEQ_EARLY_EXIT_EN to stop as soon as the running count exceeds thr.
module bitcount_seq #(
    parameter int DATA_W  = 2304,
    parameter int COUNT_W = 12,
    parameter int SLICE_W = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DATA_W-1:0]  din,
    input  logic [COUNT_W-1:0] thr,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] cnt,
    output logic               zero,
    output logic               over
);
    localparam int NSLICE = DATA_W / SLICE_W;
    localparam int IDX_W  = NSLICE > 1 ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t             state;
    logic [DATA_W-1:0]  sh;
    logic [COUNT_W-1:0] acc, slice_sum, nxt;
    logic [IDX_W-1:0]   idx;
    logic               last, early;

    function automatic logic [3:0] pop8(input logic [7:0] b);
        pop8 = '0;
        for (int j = 0; j < 8; j++) pop8 = pop8 + {3'b0, b[j]};
    endfunction

    always_comb begin
        slice_sum = '0;
        for (int i = 0; i < SLICE_W / 8; i++) slice_sum = slice_sum + COUNT_W'(pop8(sh[8*i +: 8]));
    end

    assign nxt  = acc + slice_sum;
    assign last = idx == IDX_W'(NSLICE - 1);

`ifdef BITCOUNT_SEQ_EARLY_EXIT_EN
    assign early = nxt > thr;
`else
    logic unused_thr;
    assign unused_thr = ^thr;
    assign early = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            zero  <= 1'b0;
            over  <= 1'b0;
            acc   <= '0;
            idx   <= '0;
            sh    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        sh    <= din;
                        acc   <= '0;
                        idx   <= '0;
                        over  <= 1'b0;
                        busy  <= 1'b1;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    acc <= nxt;
                    sh  <= sh >> SLICE_W;
                    idx <= idx + 1'b1;
                    // Last slice or threshold exceeded: publish the result
                    if (last || early) begin
                        cnt   <= nxt;
                        zero  <= nxt == '0;
                        over  <= early;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bitcount_seq.sv
// tb_bitcount_seq: directed self-checking bench for bitcount_seq with default parameters.
module tb_bitcount_seq;
    localparam int DW = 2304;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst, start, busy, done, zero, over;
    logic [DW-1:0] din, v;
    logic [CW-1:0] thr, cnt;
    logic [DW-1:0] vec [20];
    int            checks = 0, failures = 0;
    int            dcyc, np, last, k;

    bitcount_seq dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .thr(thr),
        .busy(busy), .done(done), .cnt(cnt), .zero(zero), .over(over)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Start v in cycle 0, optionally poke start in cycle poke or rst in cycle rc; observe 16 cycles.
    task automatic run(input logic [DW-1:0] vin, input logic [CW-1:0] t, input int poke,
                       input int rc, input int edone, output int dc, output int npulse);
        int nb;
        nb = 0;
        dc = -1;
        npulse = 0;
        din = vin;
        thr = t;
        start = 1'b1;
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            start = c == poke;
            if (c == poke) din = '1;
            rst = c == rc;
            if (done) begin
                npulse++;
                if (dc < 0) dc = c;
            end
            if (busy !== (c < edone)) nb++;
        end
        start = 1'b0;
        rst = 1'b0;
        check("busy_window", nb, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        din = '0;
        thr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", cnt, 0);
        check("rst_zero", zero, 0);
        check("rst_over", over, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run('0, 12'd0, -1, -1, 10, dcyc, np);
        check("zeros_done_cycle", dcyc, 10);
        check("zeros_pulses", np, 1);
        check("zeros_cnt", cnt, 0);
        check("zeros_zero", zero, 1);

        run('1, 12'd4095, -1, -1, 10, dcyc, np);
        check("ones_done_cycle", dcyc, 10);
        check("ones_cnt", cnt, 2304);
        check("ones_zero", zero, 0);

        v = '0;
        v[2303] = 1'b1;
        run(v, 12'd4095, -1, -1, 10, dcyc, np);
        check("msb_cnt", cnt, 1);
        check("msb_zero", zero, 0);

        v = '0;
        v[299:0] = '1;
        run(v, 12'd4095, 4, -1, 10, dcyc, np);
        check("ignored_start_done_cycle", dcyc, 10);
        check("ignored_start_pulses", np, 1);
        check("ignored_start_cnt", cnt, 300);

        run('1, 12'd4095, -1, 5, 6, dcyc, np);
        check("rst_mid_pulses", np, 0);
        check("rst_mid_cnt", cnt, 0);
        check("rst_mid_zero", zero, 0);
        check("rst_mid_over", over, 0);

        run('1, 12'd4095, -1, -1, 10, dcyc, np);
        check("after_rst_done_cycle", dcyc, 10);
        check("after_rst_cnt", cnt, 2304);

        v = '0;
        v[7:0] = 8'hFF;
`ifdef BITCOUNT_SEQ_EARLY_EXIT_EN
        run(v, 12'd5, -1, -1, 2, dcyc, np);
        check("early_done_cycle", dcyc, 2);
        check("early_cnt", cnt, 8);
        check("early_over", over, 1);
        run(v, 12'd2304, -1, -1, 10, dcyc, np);
        check("noexit_done_cycle", dcyc, 10);
        check("noexit_cnt", cnt, 8);
        check("noexit_over", over, 0);
`else
        run(v, 12'd5, -1, -1, 10, dcyc, np);
        check("thr_ignored_done_cycle", dcyc, 10);
        check("thr_ignored_cnt", cnt, 8);
        check("thr_ignored_over", over, 0);
`endif

        for (int i = 0; i < 20; i++)
            for (int j = 0; j < DW / 32; j++) vec[i][32*j +: 32] = $urandom;
        din = vec[0];
        thr = 12'd4095;
        start = 1'b1;
        last = 0;
        k = 0;
        for (int c = 1; c <= 230 && k < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                check("b2b_cnt", cnt, $countones(vec[k]));
                check("b2b_period", c - last, 10);
                last = c;
                k++;
                if (k < 20) din = vec[k];
                else start = 1'b0;
            end
        end
        start = 1'b0;
        check("b2b_vectors", k, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
